// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension stage: extension modes and pipe state encodings.
// Pure declarations, no logic and no latency.
// No flow control of its own.
package imm_ext_pkg;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGN   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational IN_W -> OUT_W immediate extension (zero / sign / upper, branch with IMM_EXTEND_BRANCH_EN).
// Latency: 0 cycles, purely combinational.
// Backpressure: none, the enclosing pipe decides when the result is captured.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] ext_data
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] uext;

    assign zext = {{PAD_W{1'b0}}, in_imm};
    assign sext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};
    assign uext = {in_imm, {PAD_W{1'b0}}};

`ifdef IMM_EXTEND_BRANCH_EN
    // Word offset: the two topmost sign copies fall off, width stays OUT_W.
    logic [OUT_W-1:0] bext;
    assign bext = {sext[OUT_W-3:0], 2'b00};
`endif

    always_comb begin
        ext_data = zext;
        case (in_mode)
            EXT_SIGN:   ext_data = sext;
            EXT_UPPER:  ext_data = uext;
`ifdef IMM_EXTEND_BRANCH_EN
            EXT_BRANCH: ext_data = bext;
`endif
            default:    ext_data = zext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer (branch mode via IMM_EXTEND_BRANCH_EN).
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready comes only from the state register; drops after two unemitted items.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic [OUT_W-1:0] ext_data;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm   (in_imm),
        .in_mode  (in_mode),
        .ext_data (ext_data)
    );

    state_e           state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] or_data_q,   or_data_d;
    logic [TAG_W-1:0] or_tag_q,    or_tag_d;
    logic [OUT_W-1:0] sr_data_q,   sr_data_d;
    logic [TAG_W-1:0] sr_tag_q,    sr_tag_d;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = out_valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        or_data_d = or_data_q;
        or_tag_d  = or_tag_q;
        sr_data_d = sr_data_q;
        sr_tag_d  = sr_tag_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    or_data_d = ext_data;
                    or_tag_d  = in_tag;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    or_data_d = ext_data;
                    or_tag_d  = in_tag;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    sr_data_d = ext_data;
                    sr_tag_d  = in_tag;
                end else if (emit) begin
                    state_d   = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d   = ST_ONE;
                    or_data_d = sr_data_q;
                    or_tag_d  = sr_tag_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A same-cycle handshake is discarded; data registers are don't-care once EMPTY.
        if (flush) begin
            state_d = ST_EMPTY;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            or_data_q   <= '0;
            or_tag_q    <= '0;
            sr_data_q   <= '0;
            sr_tag_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            or_data_q   <= or_data_d;
            or_tag_q    <= or_tag_d;
            sr_data_q   <= sr_data_d;
            sr_tag_q    <= sr_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = or_data_q;
    assign out_tag   = or_tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors push expected results, a negedge monitor pops and compares.
module tb_imm_extend_pipe;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   out_cnt = 0;
    exp_t sb_q[$];

    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic [4:0]  held_tag;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per handshake and checks held data during stalls.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            out_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %h tag %0d, expected nothing", out_data, out_tag);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_data", out_data, e.data);
                check("sb_tag", {27'd0, out_tag}, {27'd0, e.tag});
            end
        end
        if (!reset && out_valid && !out_ready) begin
            if (stall_prev) begin
                check("stall_data", out_data, held_data);
                check("stall_tag", {27'd0, out_tag}, {27'd0, held_tag});
            end
            held_data  = out_data;
            held_tag   = out_tag;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                        input logic [31:0] exp, input bit push);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && push) sb_q.push_back('{exp, tag});
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 for 50 cycles, expected acceptance of tag %0d", tag);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    // Single item with out_ready=1: must show up exactly one cycle after accept.
    task automatic one_shot(input string name, input logic [15:0] imm, input logic [1:0] mode,
                            input logic [4:0] tag, input logic [31:0] exp);
        send(imm, mode, tag, exp, 1'b1);
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, {27'd0, out_tag}, {27'd0, tag});
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion within 200000 time units");
        $fatal(1);
    end

    initial begin
        logic [31:0] br_exp1;
        logic [31:0] br_exp2;
        int c0;
        int o0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);

        one_shot("zero",  16'h8001, 2'b00, 5'd3,  32'h0000_8001);
        one_shot("sign",  16'h8001, 2'b01, 5'd4,  32'hFFFF_8001);
        one_shot("upper", 16'h8001, 2'b10, 5'd5,  32'h8001_0000);
        one_shot("sign_pos",  16'h7FFF, 2'b01, 5'd6, 32'h0000_7FFF);
        one_shot("upper_mix", 16'h1234, 2'b10, 5'd7, 32'h1234_0000);
`ifdef IMM_EXTEND_BRANCH_EN
        br_exp1 = 32'hFFFF_FFFC;
        br_exp2 = 32'hFFFE_0000;
`else
        br_exp1 = 32'h0000_FFFF;
        br_exp2 = 32'h0000_8000;
`endif
        one_shot("mode11_ffff", 16'hFFFF, 2'b11, 5'd8, br_exp1);
        one_shot("mode11_8000", 16'h8000, 2'b11, 5'd9, br_exp2);

        // Stall: two accepts fill OR and SR, then in_ready must drop.
        out_ready = 1'b0;
        send(16'h0011, 2'b00, 5'd1, 32'h0000_0011, 1'b1);
        send(16'h0022, 2'b00, 5'd2, 32'h0000_0022, 1'b1);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("full_hold_ready", {31'd0, in_ready}, 32'd0);
        check("full_hold_tag", {27'd0, out_tag}, 32'd1);
        out_ready = 1'b1;
        for (int t = 3; t <= 8; t++) begin
            send(16'(t * 16'h11), 2'b00, 5'(t), {16'h0, 16'(t * 16'h11)}, 1'b1);
        end
        drain();

        // Throughput: 20 back-to-back items, one accept and one emit per cycle.
        c0 = cyc;
        o0 = out_cnt;
        for (int t = 0; t < 20; t++) begin
            send(16'(16'hF000 + t), 2'b01, 5'(t + 10), 32'hFFFF_F000 + t, 1'b1);
        end
        check("thru_accept_cycles", cyc - c0, 20);
        @(posedge clk);
        #1;
        check("thru_out_count", out_cnt - o0, 20);
        check("thru_idle_valid", {31'd0, out_valid}, 32'd0);
        drain();

        // Flush while FULL with a competing input handshake.
        out_ready = 1'b0;
        send(16'hAAAA, 2'b00, 5'd20, 32'h0, 1'b0);
        send(16'hBBBB, 2'b00, 5'd21, 32'h0, 1'b0);
        check("pre_flush_full", {31'd0, in_ready}, 32'd0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_imm   = 16'hCCCC;
        in_tag   = 5'd22;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        one_shot("post_flush", 16'h0123, 2'b00, 5'd23, 32'h0000_0123);

        // Reset while FULL.
        out_ready = 1'b0;
        send(16'hDDDD, 2'b01, 5'd24, 32'h0, 1'b0);
        send(16'hEEEE, 2'b01, 5'd25, 32'h0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst2_out_data", out_data, 32'h0);
        check("rst2_out_tag", {27'd0, out_tag}, 32'd0);
        out_ready = 1'b1;
        one_shot("post_reset", 16'h8002, 2'b01, 5'd26, 32'hFFFF_8002);

        repeat (3) @(posedge clk);
        #1;
        check("final_queue", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate-extension stage for the 32-bit MIPS datapath, placed between instruction decode and the ALU operand mux.
- Widens an IN_W-bit immediate to OUT_W bits in one of several per-transaction modes: zero, sign, upper/LUI, and optionally branch-offset.
- Moves data through a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the execute stage never drops or duplicates an immediate.

Parameters:
- IN_W, 16, immediate input width; must be ≥1.
- OUT_W, 32, extended output width; must be ≥ IN_W + 2.
- TAG_W, 5, width of the sideband tag (e.g. destination register) carried alongside the data.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline clear; priority below reset, above handshake.
- in_valid  input  1  upstream holds a valid immediate.
- in_ready  output  1  stage can accept; registered, equals skid entry empty.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode; see EXT_* constants.
- in_tag  input  TAG_W  sideband, passed through unmodified.
- out_valid  output  1  out_data/out_tag valid.
- out_ready  input  1  downstream accepts.
- out_data  output  OUT_W  extended immediate.
- out_tag  output  TAG_W  tag matching out_data.

Behaviour:
- Only clk and reset are clocking/reset inputs. Reset is synchronous and active-high. There is no asynchronous path.
- Extension, computed combinationally on in_imm and captured at acceptance:
  - EXT_ZERO (00): upper OUT_W−IN_W bits are 0, low bits = in_imm.
  - EXT_SIGN (01): upper bits replicate in_imm[IN_W−1].
  - EXT_UPPER (10): in_imm in bits [OUT_W−1:OUT_W−IN_W], lower bits 0. For 16→32 this is imm<<16.
  - 11: see Optional Feature.
- Accept when in_valid && in_ready. Emit when out_valid && out_ready.
- Storage: output register (OR) plus skid register (SR).
- States (2-bit):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: OR valid, SR empty, in_ready=1.
  - FULL: OR and SR valid, in_ready=0.
- Transitions:
  - EMPTY + accept → ONE; OR loaded. Latency 1 cycle from accept to out_valid.
  - ONE + accept + emit → ONE; OR reloaded with new data.
  - ONE + accept, no emit → FULL; new data goes to SR.
  - ONE + emit, no accept → EMPTY.
  - FULL + emit → ONE; SR moves to OR. No accept is possible in FULL.
  - All other combinations hold state and registers.
- Ordering is strict FIFO. Every accepted item is emitted exactly once.
- out_data/out_tag are stable while out_valid=1 and out_ready=0.
- in_ready is driven from the state register only. There is no combinational path from out_ready to in_ready.
- flush=1: next state EMPTY, out_valid=0, in_ready=1. A handshake in the same cycle is discarded.
- Reset mid-transfer behaves identically to flush.
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, state=EMPTY, SR contents=0.
- Data registers are loaded only on accept or SR→OR move.

Optional Feature:
- Macro IMM_EXTEND_BRANCH_EN.
- Defined: mode 11 = EXT_BRANCH, i.e. sign-extend then shift left 2. Bits [1:0]=0, top two sign bits are dropped, result width stays OUT_W.
- Undefined: mode 11 behaves exactly as EXT_ZERO, and no shifter logic is generated.

Decomposition:
- Package imm_ext_pkg holds:
  - mode constants EXT_ZERO, EXT_SIGN, EXT_UPPER, EXT_BRANCH (2-bit);
  - state encodings ST_EMPTY=0, ST_ONE=1, ST_FULL=2.
- One combinational sub-module, imm_ext_core (in_imm, in_mode → ext_data), holds all mode logic.
- The pipe module instantiates it once and contains only the state machine and registers.

Test Plan:
- Reset, then in_imm=16'h8001, each mode, out_ready=1 → out_data is:
  - 32'h00008001 (zero);
  - 32'hFFFF8001 (sign);
  - 32'h80010000 (upper).
  - Each appears 1 cycle after accept with the correct tag.
- IMM_EXTEND_BRANCH_EN defined, mode 11, imm 16'hFFFF → 32'hFFFFFFFC.
  - Macro undefined, same stimulus → 32'h0000FFFF.
- Stream tags 1..8 with out_ready=0 for cycles 2–4:
  - in_ready falls after 2 accepts;
  - no loss or duplication;
  - tags emerge in order 1..8;
  - out_data is held stable while stalled.
- Full throughput: in_valid=1 and out_ready=1 continuously for 20 items → one output per cycle after the first, and state stays ONE.
- State FULL, then flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed items never appear.
- reset asserted while FULL → next cycle all outputs at their reset values; first post-reset accept emerges 1 cycle later.
